// File: rtl/async_fifo_rd_pkg.sv
// -----------------------------------------------------------------------------
// async_fifo_rd_pkg
// Shared types and helpers for the async FIFO read-side burst reader.
//   rd_state_e       : reader FSM states (IDLE, FILL, BURST)
//   clamp_burst_len  : maps a raw burst-length request onto 1..max_burst
// -----------------------------------------------------------------------------
package async_fifo_rd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        BURST = 2'd2
    } rd_state_e;

    // A request of 0 still produces a one-beat burst; anything larger than
    // the burst ceiling is trimmed to it.
    function automatic int unsigned clamp_burst_len(input int unsigned len,
                                                    input int unsigned max_burst);
        if (len == 0) begin
            return 1;
        end
        if (len > max_burst) begin
            return max_burst;
        end
        return len;
    endfunction

endpackage

// File: rtl/fifo_rd_hold_stage.sv
// -----------------------------------------------------------------------------
// fifo_rd_hold_stage
// Two-register pipeline between the FIFO read port and the valid/ready output.
// H (holdback) receives popped words; O (output) drives the downstream beat.
// A word leaves H only once its last flag is known: either it is already
// marked last, or a successor word is waiting in the FIFO (so it cannot be
// the last beat of a short burst).
//
// Ports:
//   r_clk, r_rst   : read clock, asynchronous active-high reset
//   h_load         : pop strobe; H captures h_load_dat / h_load_last
//   h_load_dat     : FIFO head word being popped
//   h_load_last    : popped word closes the burst
//   h_set_last     : idle timeout; mark the word held in H as last
//   succ_avail     : FIFO holds at least one more word (r_empty = 0)
//   m_ready        : downstream accepts the beat in O
//   h_full, h_last : H occupancy and its last flag
//   h_move         : H is transferred into O this cycle
//   m_valid, m_dat, m_last : output beat (m_valid = O full)
// -----------------------------------------------------------------------------
module fifo_rd_hold_stage #(
    parameter int DW = 10
) (
    input  logic          r_clk,
    input  logic          r_rst,
    input  logic          h_load,
    input  logic [DW-1:0] h_load_dat,
    input  logic          h_load_last,
    input  logic          h_set_last,
    input  logic          succ_avail,
    input  logic          m_ready,
    output logic          h_full,
    output logic          h_last,
    output logic          h_move,
    output logic          m_valid,
    output logic [DW-1:0] m_dat,
    output logic          m_last
);

    logic [DW-1:0] h_dat;

    // O is free when empty or when its beat is being accepted right now.
    assign h_move = h_full && (!m_valid || m_ready) && (h_last || succ_avail);

    // NOTE: registers are updated with non-blocking assignments so every
    // always_ff sees the pre-edge value of every other register.
    always_ff @(posedge r_clk or posedge r_rst) begin
        if (r_rst) begin
            h_full <= 1'b0;
            h_last <= 1'b0;
            h_dat  <= '0;
        end else if (h_load) begin
            // A pop only happens when H is empty or moving out this cycle,
            // so loading always wins over the clear.
            h_full <= 1'b1;
            h_dat  <= h_load_dat;
            h_last <= h_load_last;
        end else begin
            if (h_move) begin
                h_full <= 1'b0;
            end
            if (h_set_last) begin
                h_last <= 1'b1;
            end
        end
    end

    // NOTE: the data registers are reset as well because m_dat is a visible
    // output that must read 0 after reset, not just be qualified by m_valid.
    always_ff @(posedge r_clk or posedge r_rst) begin
        if (r_rst) begin
            m_valid <= 1'b0;
            m_dat   <= '0;
            m_last  <= 1'b0;
        end else if (h_move) begin
            m_valid <= 1'b1;
            m_dat   <= h_dat;
            m_last  <= h_last;
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/async_fifo_burst_reader.sv
// -----------------------------------------------------------------------------
// async_fifo_burst_reader
// Read-domain consumer of the async FIFO's first-word-fall-through port.
// Waits for the FIFO to fill (or a timeout), then pops up to BL words and
// presents them as a valid/ready burst terminated by m_last. A burst that
// runs dry is closed by an idle timeout on the word still held back.
//
// Ports:
//   r_clk, r_rst          : read clock, asynchronous active-high reset
//   r_en                  : FIFO pop strobe
//   o_dat                 : FIFO head word (valid while r_empty = 0)
//   r_empty               : FIFO empty flag
//   r_almost_empty        : FIFO almost-empty flag
//   m_valid/m_ready       : output handshake
//   m_dat, m_last         : output beat data and end-of-burst marker
//   cfg_burst_len         : beats per burst (0 -> 1, clamped to MAX_BURST)
//   cfg_timeout           : fill-wait and short-burst idle limit in cycles
//   busy                  : reader is not idle
//   burst_cnt             : completed bursts, wrapping
// -----------------------------------------------------------------------------
module async_fifo_burst_reader
    import async_fifo_rd_pkg::*;
#(
    parameter int DW        = 10,
    parameter int MAX_BURST = 16,
    parameter int TW        = 8
) (
    input  logic                         r_clk,
    input  logic                         r_rst,
    output logic                         r_en,
    input  logic [DW-1:0]                o_dat,
    input  logic                         r_empty,
    input  logic                         r_almost_empty,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [DW-1:0]                m_dat,
    output logic                         m_last,
    input  logic [$clog2(MAX_BURST):0]   cfg_burst_len,
    input  logic [TW-1:0]                cfg_timeout,
    output logic                         busy,
    output logic [15:0]                  burst_cnt
);

    localparam int BLW = $clog2(MAX_BURST) + 1;

    rd_state_e      state;
    logic [BLW-1:0] bl_q;      // clamped burst length for this burst
    logic [BLW-1:0] pcnt;      // words popped in this burst
    logic [TW-1:0]  to_q;      // timeout latched for this burst
    logic [TW-1:0]  tmr;       // fill-wait countdown
    logic [TW-1:0]  itmr;      // idle counter for the held-back word
    logic           closed;    // idle timeout already ended the burst early

    logic h_full;
    logic h_last;
    logic h_move;
    logic h_load_last;
    logic idle_run;
    logic h_set_last;
    logic beat_end;

    // Pops need room in H; the closed flag stops a timed-out burst from
    // pulling in words that arrive after its last beat was decided.
    assign r_en = (state == BURST) && !r_empty && !closed && (pcnt < bl_q)
                  && (!h_full || h_move);

    assign h_load_last = (pcnt == bl_q - BLW'(1));
    assign idle_run    = (state == BURST) && h_full && !h_last && r_empty;
    assign h_set_last  = idle_run && (itmr == to_q);
    assign beat_end    = m_valid && m_ready && m_last;

    fifo_rd_hold_stage #(
        .DW (DW)
    ) u_hold (
        .r_clk       (r_clk),
        .r_rst       (r_rst),
        .h_load      (r_en),
        .h_load_dat  (o_dat),
        .h_load_last (h_load_last),
        .h_set_last  (h_set_last),
        .succ_avail  (!r_empty),
        .m_ready     (m_ready),
        .h_full      (h_full),
        .h_last      (h_last),
        .h_move      (h_move),
        .m_valid     (m_valid),
        .m_dat       (m_dat),
        .m_last      (m_last)
    );

    always_ff @(posedge r_clk or posedge r_rst) begin
        if (r_rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            burst_cnt <= '0;
            bl_q      <= '0;
            pcnt      <= '0;
            to_q      <= '0;
            tmr       <= '0;
            itmr      <= '0;
            closed    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!r_empty) begin
                        bl_q  <= BLW'(clamp_burst_len(32'(cfg_burst_len), MAX_BURST));
                        to_q  <= cfg_timeout;
                        tmr   <= cfg_timeout;
                        busy  <= 1'b1;
                        state <= FILL;
                    end
                end

                FILL: begin
                    if (!r_almost_empty || tmr == '0) begin
                        state <= BURST;
                    end else begin
                        tmr <= tmr - TW'(1);
                    end
                end

                BURST: begin
                    if (r_en) begin
                        pcnt <= pcnt + BLW'(1);
                        itmr <= '0;
                    end else if (idle_run) begin
                        if (itmr == to_q) begin
                            closed <= 1'b1;
                        end else begin
                            itmr <= itmr + TW'(1);
                        end
                    end
                    // The last beat is already in O, so no pop can coincide.
                    if (beat_end) begin
                        burst_cnt <= burst_cnt + 16'd1;
                        pcnt      <= '0;
                        itmr      <= '0;
                        closed    <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/async_fifo_burst_reader.md
Name: async_fifo_burst_reader

Overview:
Read-side consumer for the async FIFO, living entirely in the read clock domain. It pops words through the FIFO's first-word-fall-through read port (r_en / o_dat / r_empty / r_almost_empty) and repackages them as valid/ready bursts with a last marker. It waits for the FIFO to fill (almost_empty deasserted) or for a timeout before starting a burst, so downstream sees dense bursts. Short bursts are closed by an idle timeout.

Parameters:
DW, 10, data width; must match the FIFO's DW.
MAX_BURST, 16, maximum beats per burst; power of 2, at least 2.
TW, 8, width of the timeout config and of the internal timers.

Ports:
r_clk  in  1  read-domain clock; the only clock.
r_rst  in  1  asynchronous, active-high reset.
r_en  out  1  FIFO pop strobe; to FIFO r_en.
o_dat  in  DW  FIFO head word; valid whenever r_empty=0.
r_empty  in  1  FIFO empty flag.
r_almost_empty  in  1  FIFO almost-empty flag.
m_valid  out  1  output beat valid.
m_ready  in  1  downstream accepts a beat.
m_dat  out  DW  output beat data.
m_last  out  1  final beat of the burst.
cfg_burst_len  in  $clog2(MAX_BURST)+1  beats per burst; 0 is treated as 1; values above MAX_BURST are clamped to MAX_BURST.
cfg_timeout  in  TW  cycles allowed for fill wait and for short-burst idle.
busy  out  1  state != IDLE.
burst_cnt  out  16  count of completed bursts; wraps.

Behaviour:
- Reset (async, r_rst=1): state IDLE; r_en=0, m_valid=0, m_dat=0, m_last=0, busy=0, burst_cnt=0; H/O registers empty; all counters 0. Words held in H/O are discarded; the FIFO itself is not reset by this block.
- Storage:
  - Holdback register H (data plus h_last flag).
  - Output register O, which drives m_dat, m_last and m_valid (m_valid = O full).
- Config: cfg_burst_len and cfg_timeout are latched on IDLE exit and held for the whole burst.
- States:
  - IDLE: if r_empty=0, latch config, load tmr=cfg_timeout, go to FILL.
  - FILL:
    - go to BURST when r_almost_empty=0, or when tmr==0;
    - otherwise decrement tmr each cycle.
    - cfg_timeout=0 means FILL lasts exactly 1 cycle.
  - BURST:
    - Pop: r_en = !r_empty & (pcnt < BL) & (H empty | H moving to O this cycle). On a pop, H <= o_dat, h_last <= (pcnt == BL-1), pcnt++.
    - H to O move: when O is free or accepted this cycle (m_valid & m_ready), AND (h_last=1, or r_empty=0, i.e. a successor word exists).
    - Idle timer: while H is full, h_last=0 and r_empty=1, itmr counts up. When itmr == cfg_timeout, set h_last=1 (short burst). Any pop clears itmr.
    - A beat with m_valid & m_ready & m_last: burst_cnt++, clear pcnt/itmr, go to IDLE; busy drops the next cycle.
- Latency:
  - Minimum from the first pop to the first m_valid: 2 cycles (pop edge to H, then H to O).
  - Sustained throughput: 1 beat per cycle with m_ready=1 and the FIFO non-empty.
- Backpressure: m_dat and m_last are held stable while m_valid & !m_ready. No pops occur while both H and O are full.
- Simultaneous pop and move: allowed in the same cycle, where O takes old H and H takes the new word.
- r_en is never asserted while r_empty=1.
- Exactly one m_last per burst; never more than BL beats per burst.
- BL=1: the first pop sets h_last=1 and the burst is 1 beat.
- burst_cnt wraps from 0xFFFF to 0.

Decomposition:
- Package async_fifo_rd_pkg:
  - state enum (IDLE, FILL, BURST);
  - function clamping cfg_burst_len to 1..MAX_BURST.
- Sub-module fifo_rd_hold_stage: the H/O two-register pipeline with last flags and valid/ready; the FSM and counters stay in the top level.

Test Plan:
- Reset, then preload 20 words (FIFO almost_empty=0), BL=8, m_ready=1: FILL lasts 1 cycle, then 8 beats in consecutive cycles with m_last on beat 8, burst_cnt=1, data in FIFO order.
- Preload 3 words (almost_empty=1), cfg_timeout=5, BL=8: FILL waits 5 cycles; 3 beats are emitted, with m_last on beat 3 asserted after the 5-cycle idle timeout; burst_cnt=1.
- 8-beat burst with m_ready toggling 1,0,0,1,...: m_dat/m_last stable while stalled; no r_en while H and O are full; all 8 words correct with no duplicates.
- cfg_burst_len=0 and cfg_burst_len=MAX_BURST+5: bursts of 1 and MAX_BURST beats respectively.
- Assert r_rst mid-burst after 3 beats: all outputs return to reset values immediately; the next burst restarts with pcnt=0 and burst_cnt=0.
- Random write traffic into the FIFO for 2000 words, random m_ready: scoreboard matches all data; r_en never asserted while r_empty=1; exactly one m_last per burst.
